// File: rtl/mem_refill_responder.sv
// -----------------------------------------------------------------------------
// mem_refill_responder
//
// Main-memory side of the cache refill interface. Accepts one word-read
// request at a time, holds it for a fixed LATENCY, then returns a single
// response beat carrying the word and an echo of the requested address.
// A synchronous write port preloads and updates the backing array.
//
// Parameters
//   ADDR_W   word-address width; the array holds 2**ADDR_W words
//   DATA_W   data word width
//   LATENCY  cycles from acceptance to response, legal range 1..15
//
// Ports
//   clk        single clock, rising-edge
//   rst        asynchronous, active-low reset
//   req_valid  cache presents a refill request
//   req_addr   requested word address
//   req_ready  responder can accept a request this cycle (high in IDLE)
//   rsp_valid  one-cycle response pulse, no backpressure
//   rsp_addr   echo of the accepted request address (holds after RESP)
//   rsp_data   word read from the array (holds after RESP)
//   wr_en      synchronous array write strobe
//   wr_addr    write address
//   wr_data    write data
// -----------------------------------------------------------------------------
module mem_refill_responder #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // The counter is loaded with LATENCY-1 so that the WAIT state lasts
  // exactly LATENCY cycles; LATENCY=1 therefore enters WAIT already at 0.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;
  logic              capture;
  logic              fwd_hit;

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    capture   = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A write landing on the latched address in the capture cycle has not yet
  // reached the array, so it is forwarded straight into rsp_data.
  assign fwd_hit = wr_en && (wr_addr == addr_q);

  // ---------------------------------------------------------------------------
  // Control and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      rsp_addr <= '0;
      rsp_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= req_addr;
      end
      if (capture) begin
        rsp_addr <= addr_q;
        rsp_data <= fwd_hit ? wr_data : mem[addr_q];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Backing array
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately not reset; reset only blocks writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // contents are left untouched while reset is asserted
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule
